bitstream_fetch: RTL and testbench

Read-side counterpart of the capture path. It accepts a fetch command (byte address and byte length) for a bitstream already stored in memory. It issues AXI4 INCR read bursts on a master read port and replays the returned data as an AXI-Stream with correct tkeep and tlast, ready for the reconfiguration engine. It runs on the memory clock domain, with one outstanding burst at a time.

---
 rtl/bitstream_fetch_pkg.sv | 17 +
 rtl/bitstream_fetch_axis_out_reg.sv | 49 ++++
 rtl/bitstream_fetch.sv | 191 +++++++++++++++++++
 tb/tb_bitstream_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitstream_fetch_pkg.sv
// Shared types and AXI constants for the bitstream fetch path.
// FSM encoding plus fixed AXI attribute values.
package bitstream_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         BOUNDARY_4K       = 4096;

endpackage

// File: rtl/bitstream_fetch_axis_out_reg.sv
// Single-entry AXI-Stream output register.
// Accepts a new beat whenever empty or draining in the same cycle.
module axis_out_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_last,
  input  logic                  i_tready,
  output logic                  o_ready,
  output logic                  o_tvalid,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic [KEEP_WIDTH-1:0] o_tkeep,
  output logic                  o_tlast
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;

  assign o_ready  = !r_valid || i_tready;
  assign o_tvalid = r_valid;
  assign o_tdata  = r_data;
  assign o_tkeep  = r_keep;
  assign o_tlast  = r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_tready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/bitstream_fetch.sv
// Fetches a stored bitstream over AXI4 INCR reads and replays it
// as AXI-Stream with tkeep/tlast, one outstanding burst at a time.
module bitstream_fetch
  import bitstream_fetch_pkg::*;
#(
  parameter int                DATA_WIDTH    = 512,
  parameter int                KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int                ADDR_WIDTH    = 34,
  parameter int                ID_WIDTH      = 6,
  parameter logic [ID_WIDTH-1:0] AXI_ID      = '0,
  parameter int                MAX_BURST_LEN = 16,
  parameter int                LEN_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  s_cmd_len,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  sts_valid,
  output logic                  sts_error,
  output logic                  busy
);

  localparam int BYTES = KEEP_WIDTH;
  localparam int SIZE  = $clog2(BYTES);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_bytes_left;
  logic [8:0]            r_burst_left;
  logic                  r_err;
  logic                  r_arvalid;
  logic                  r_sts_valid;
  logic                  r_sts_error;

  logic [LEN_WIDTH-1:0]  w_beats_rem;
  logic [12:0]           w_4k_room;
  logic [8:0]            w_beats;
  logic                  w_last_beat;
  logic [SIZE-1:0]       w_rem;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic                  w_out_ready;
  logic                  w_rbeat;
  logic                  w_unused;

  assign w_unused = ^m_axi_rid;

  assign w_beats_rem = (r_bytes_left >> SIZE)
                     + LEN_WIDTH'(|r_bytes_left[SIZE-1:0]);
  assign w_4k_room = (13'(BOUNDARY_4K) - {1'b0, r_cur_addr[11:0]}) >> SIZE;

  always_comb begin
    w_beats = 9'(MAX_BURST_LEN);
    if (w_4k_room < 13'(w_beats))
      w_beats = w_4k_room[8:0];
    if (w_beats_rem < LEN_WIDTH'(w_beats))
      w_beats = w_beats_rem[8:0];
  end

  // A partial trailing beat only ever occurs on the final command beat.
  assign w_last_beat = (r_bytes_left <= LEN_WIDTH'(BYTES));
  assign w_rem       = r_bytes_left[SIZE-1:0];
  assign w_keep      = (w_last_beat && w_rem != '0)
                     ? (KEEP_WIDTH'(1) << w_rem) - KEEP_WIDTH'(1)
                     : '1;

  assign w_rbeat = (r_state == S_DATA) && m_axi_rvalid && w_out_ready;

  assign s_cmd_ready   = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign m_axi_arid    = AXI_ID;
  assign m_axi_araddr  = r_cur_addr;
  assign m_axi_arlen   = 8'(w_beats - 9'd1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = (r_state == S_DATA) && w_out_ready;
  assign sts_valid     = r_sts_valid;
  assign sts_error     = r_sts_error;

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_rbeat),
    .i_data  (m_axi_rdata),
    .i_keep  (w_keep),
    .i_last  (w_last_beat),
    .i_tready(m_axis_tready),
    .o_ready (w_out_ready),
    .o_tvalid(m_axis_tvalid),
    .o_tdata (m_axis_tdata),
    .o_tkeep (m_axis_tkeep),
    .o_tlast (m_axis_tlast)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_bytes_left <= '0;
      r_burst_left <= '0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_sts_valid  <= 1'b0;
      r_sts_error  <= 1'b0;
    end else begin
      r_sts_valid <= 1'b0;
      r_sts_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (s_cmd_valid) begin
            r_cur_addr   <= s_cmd_addr;
            r_bytes_left <= s_cmd_len;
            r_err        <= 1'b0;
            if (s_cmd_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid    <= 1'b0;
            r_burst_left <= w_beats;
            r_cur_addr   <= r_cur_addr
                          + (ADDR_WIDTH'(w_beats) << SIZE);
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_rbeat) begin
            r_bytes_left <= w_last_beat ? '0
                          : r_bytes_left - LEN_WIDTH'(BYTES);
            r_burst_left <= r_burst_left - 9'd1;
            // Beat counter, not rlast, decides where the burst ends.
            if (m_axi_rresp != AXI_RESP_OKAY ||
                m_axi_rlast != (r_burst_left == 9'd1))
              r_err <= 1'b1;
            if (r_burst_left == 9'd1) begin
              if (w_last_beat) begin
                r_state <= S_DONE;
              end else begin
                r_state   <= S_ADDR;
                r_arvalid <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (!m_axis_tvalid || m_axis_tready) begin
            r_sts_valid <= 1'b1;
            r_sts_error <= r_err;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_fetch.sv
// Directed bench for bitstream_fetch with a simple AXI read slave
// and an AXIS sink that logs every transfer.
module tb_bitstream_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [33:0]  s_cmd_addr = '0;
  logic [31:0]  s_cmd_len = '0;
  logic         s_cmd_valid = 1'b0;
  logic         s_cmd_ready;
  logic [5:0]   arid;
  logic [33:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [5:0]   rid = '0;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic         sts_valid;
  logic         sts_error;
  logic         busy;

  always #5 clk = ~clk;

  bitstream_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .sts_valid(sts_valid),
    .sts_error(sts_error), .busy(busy)
  );

  typedef struct {
    logic [33:0] addr;
    logic [31:0] len;
    bit          rnd;
    int          err_beat;
    bit          early;
    int          n_ar;
    logic [33:0] a0;
    logic [7:0]  l0;
    logic [33:0] a1;
    logic [7:0]  l1;
    int          n_beats;
    logic [63:0] last_keep;
    bit          exp_err;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  bit rnd = 0;
  int err_beat = -1;
  bit early = 0;

  logic [33:0]  ar_addr_q[$];
  logic [7:0]   ar_len_q[$];
  logic [2:0]   ar_size_q[$];
  logic [511:0] bt_data_q[$];
  logic [63:0]  bt_keep_q[$];
  logic         bt_last_q[$];
  int sts_cnt = 0;
  logic sts_err_v = 1'b0;
  int cyc_tl = 0;
  int cyc_sts = 0;
  int ovl = 0;

  logic [33:0] r_addr;
  int r_rem = 0;
  int r_idx = 0;
  int gbeat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input logic [33:0] a);
    return {16{a[31:0] ^ 32'h5A00_00C3}};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // AXI read slave, AXIS sink and transfer logger.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    rresp = 2'b00; rlast = 1'b0; tready = 1'b1; r_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_rem = 0; rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
      end else begin
        arready = ($urandom_range(0, 3) != 0);
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (r_rem > 0) begin
          rvalid = 1'b1;
          rdata = pat(r_addr);
          rresp = (gbeat == err_beat) ? 2'b10 : 2'b00;
          rlast = (r_rem == 1) || (early && r_idx == 0 && r_rem > 1);
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        #1;
        if (s_cmd_valid && s_cmd_ready) begin
          ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete();
          bt_data_q.delete(); bt_keep_q.delete(); bt_last_q.delete();
          gbeat = 0; sts_cnt = 0;
        end
        if (rvalid && rready) begin
          r_addr = r_addr + 34'd64; r_rem--; r_idx++; gbeat++;
        end
        if (arvalid && arready) begin
          ar_addr_q.push_back(araddr);
          ar_len_q.push_back(arlen);
          ar_size_q.push_back(arsize);
          if (r_rem != 0) ovl++;
          r_addr = araddr; r_rem = int'(arlen) + 1; r_idx = 0;
        end
        if (tvalid && tready) begin
          bt_data_q.push_back(tdata);
          bt_keep_q.push_back(tkeep);
          bt_last_q.push_back(tlast);
          if (tlast) cyc_tl = cyc;
        end
        if (sts_valid) begin
          sts_cnt++; sts_err_v = sts_error; cyc_sts = cyc;
        end
      end
    end
  end

  task automatic send(input logic [33:0] a, input logic [31:0] l);
    @(negedge clk);
    s_cmd_addr = a; s_cmd_len = l; s_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (sts_cnt != 0) begin ok = 1; break; end
    end
    chk({nm, "_done"}, ok, 1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    logic [63:0] ek;
    err_beat = v.err_beat; early = v.early; rnd = v.rnd;
    send(v.addr, v.len);
    chk({nm, "_arvalid_n1"}, arvalid, 1);
    chk({nm, "_araddr_n1"}, araddr, v.addr);
    wait_done(nm);
    chk({nm, "_n_ar"}, ar_addr_q.size(), v.n_ar);
    if (ar_addr_q.size() > 0) begin
      chk({nm, "_ar0_addr"}, ar_addr_q[0], v.a0);
      chk({nm, "_ar0_len"}, ar_len_q[0], v.l0);
      chk({nm, "_ar0_size"}, ar_size_q[0], 3'd6);
    end
    if (v.n_ar > 1 && ar_addr_q.size() > 1) begin
      chk({nm, "_ar1_addr"}, ar_addr_q[1], v.a1);
      chk({nm, "_ar1_len"}, ar_len_q[1], v.l1);
    end
    chk({nm, "_n_beats"}, bt_data_q.size(), v.n_beats);
    n = (bt_data_q.size() < v.n_beats) ? bt_data_q.size() : v.n_beats;
    for (int k = 0; k < n; k++) begin
      ek = (k == v.n_beats - 1) ? v.last_keep : 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("%s_data%0d", nm, k), bt_data_q[k],
          pat(v.addr + 34'(k * 64)));
      chk($sformatf("%s_keep%0d", nm, k), bt_keep_q[k], ek);
      chk($sformatf("%s_last%0d", nm, k), bt_last_q[k],
          k == v.n_beats - 1);
    end
    chk({nm, "_sts_error"}, sts_err_v, v.exp_err);
    chk({nm, "_sts_lat"}, cyc_sts - cyc_tl, 1);
    err_beat = -1; early = 0; rnd = 0;
  endtask

  vec_t vecs[7];
  bit   reached;

  initial begin
    vecs[0] = '{34'h1000, 32'd256, 0, -1, 0, 1, 34'h1000, 8'd3,
                34'h0, 8'd0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[1] = '{34'h2000, 32'd100, 0, -1, 0, 1, 34'h2000, 8'd1,
                34'h0, 8'd0, 2, 64'h0000_000F_FFFF_FFFF, 0};
    vecs[2] = '{34'h0FC0, 32'd192, 0, -1, 0, 2, 34'h0FC0, 8'd0,
                34'h1000, 8'd1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[3] = '{34'h0, 32'd2048, 1, -1, 0, 2, 34'h0, 8'd15,
                34'h400, 8'd15, 32, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[4] = '{34'h3000, 32'd256, 0, 1, 0, 1, 34'h3000, 8'd3,
                34'h0, 8'd0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5] = '{34'h4000, 32'd128, 0, -1, 1, 1, 34'h4000, 8'd1,
                34'h0, 8'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6] = '{34'h0F80, 32'd200, 0, -1, 0, 2, 34'h0F80, 8'd1,
                34'h1000, 8'd1, 4, 64'h0000_0000_0000_00FF, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_sts_error", sts_error, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", s_cmd_ready, 1);

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Zero-length command: status two cycles after acceptance.
    send(34'h5000, 32'd0);
    chk("zl_sts_n1", sts_valid, 0);
    chk("zl_busy_n1", busy, 1);
    @(posedge clk);
    #1;
    chk("zl_sts_n2", sts_valid, 1);
    chk("zl_err_n2", sts_error, 0);
    chk("zl_arvalid", arvalid, 0);
    @(posedge clk);
    #1;
    chk("zl_sts_n3", sts_valid, 0);
    chk("zl_no_ar", ar_addr_q.size(), 0);

    // Reset in the middle of a 1024-byte fetch.
    rnd = 1;
    send(34'h8000, 32'd1024);
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #2;
      if (bt_data_q.size() >= 2 && busy) begin reached = 1; break; end
    end
    chk("mr_reach_data", reached, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_arvalid", arvalid, 0);
    chk("mr_rready", rready, 0);
    chk("mr_tvalid", tvalid, 0);
    chk("mr_tlast", tlast, 0);
    chk("mr_sts_valid", sts_valid, 0);
    chk("mr_sts_error", sts_error, 0);
    chk("mr_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rnd = 0;
    run_vec(vecs[0], "after_rst");

    chk("one_outstanding", ovl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
